// File: rtl/max7219_pkg.sv
// Shared constants, state/phase encodings and word formatting for the MAX7219 16x16 matrix driver.
package max7219_pkg;

  localparam logic [3:0] REG_NOOP      = 4'h0;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DIGIT1    = 4'h2;
  localparam logic [3:0] REG_DIGIT2    = 4'h3;
  localparam logic [3:0] REG_DIGIT3    = 4'h4;
  localparam logic [3:0] REG_DIGIT4    = 4'h5;
  localparam logic [3:0] REG_DIGIT5    = 4'h6;
  localparam logic [3:0] REG_DIGIT6    = 4'h7;
  localparam logic [3:0] REG_DIGIT7    = 4'h8;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_DISPTEST  = 4'hF;

  localparam int unsigned INIT_CMDS = 5;
  localparam int unsigned ROWS      = 8;
  localparam int unsigned WORD_W    = 64;
  localparam int unsigned FRAME_W   = 256;

  typedef enum logic [1:0] {ST_INIT, ST_SNAP, ST_ROWS, ST_WAIT} state_e;
  typedef enum logic [1:0] {PH_CS_SETUP, PH_BIT_LO, PH_BIT_HI, PH_CS_HOLD} phase_e;

  // Same init command broadcast to all four devices.
  function automatic logic [WORD_W-1:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
    logic [11:0] cmd;
    case (idx)
      3'd0:    cmd = {REG_DISPTEST, 8'h00};
      3'd1:    cmd = {REG_DECODE, 8'h00};
      3'd2:    cmd = {REG_SCANLIMIT, 8'h07};
      3'd3:    cmd = {REG_INTENSITY, 4'h0, intensity};
      default: cmd = {REG_SHUTDOWN, 8'h01};
    endcase
    return {4{4'h0, cmd}};
  endfunction

  // Row r of each 8x8 quadrant; device d sits at x offset (d%2)*8, y offset (d/2)*8.
  function automatic logic [WORD_W-1:0] row_word(input logic [FRAME_W-1:0] frame, input logic [2:0] r);
    logic [WORD_W-1:0] w;
    logic [7:0]        data;
    w    = '0;
    data = '0;
    for (int d = 0; d < 4; d++) begin
      for (int b = 0; b < 8; b++)
        data[3'(b)] = frame[8'((((d / 2) * 8) + int'(r)) * 16 + ((d % 2) * 8) + b)];
      w[6'(d * 16) +: 16] = {4'h0, REG_DIGIT0 + 4'(r), data};
    end
    return w;
  endfunction

endpackage

// File: rtl/spi_word_tx.sv
// Shifts one 64-bit word MSB first over a write-only SPI link; a transaction lasts 130*CLK_DIV cycles.
module spi_word_tx
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              ready_c,
  output logic              done_c
);

  localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic              active_q, active_d;
  phase_e            phase_q, phase_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [5:0]        bit_q, bit_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              div_last;

  assign div_last = (div_q == DIV_LAST);
  assign done_c   = active_q && (phase_q == PH_CS_HOLD) && div_last;
  // A new word may start in the final hold cycle so transactions run back to back.
  assign ready_c  = !active_q || done_c;

  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    if (active_q) begin
      div_d = div_last ? '0 : div_q + DIV_W'(1);
      if (div_last) begin
        case (phase_q)
          PH_CS_SETUP: phase_d = PH_BIT_LO;
          PH_BIT_LO: begin
            phase_d = PH_BIT_HI;
            sclk_d  = 1'b1;
          end
          PH_BIT_HI: begin
            sclk_d = 1'b0;
            if (bit_q == 6'd0) begin
              phase_d = PH_CS_HOLD;
              cs_n_d  = 1'b1;
            end else begin
              phase_d = PH_BIT_LO;
              bit_d   = bit_q - 6'd1;
              shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
              mosi_d  = shreg_q[WORD_W-2];
            end
          end
          default: active_d = 1'b0;
        endcase
      end
    end
    if (start && ready_c) begin
      active_d = 1'b1;
      phase_d  = PH_CS_SETUP;
      div_d    = '0;
      bit_d    = 6'd63;
      shreg_d  = word;
      sclk_d   = 1'b0;
      mosi_d   = word[WORD_W-1];
      cs_n_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      phase_q  <= PH_CS_SETUP;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
    end
  end

  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;

endmodule

// File: rtl/max7219_matrix_driver.sv
// Initialises a chain of four MAX7219s, then periodically snapshots the 16x16 frame and streams its 8 rows.
module max7219_matrix_driver
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned REFRESH_CYCLES = 10000,
  parameter logic [3:0]  INTENSITY      = 4'd8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] matrix,
  output logic               spi_sclk,
  output logic               spi_mosi,
  output logic               spi_cs_n,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned     WAIT_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(REFRESH_CYCLES - 1);

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               start_c;
  logic [WORD_W-1:0]  word_c;
  logic               tx_ready_c, tx_done_c;

  // idx_q counts the next command/row to launch; the FSM advances when the last one completes.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    frame_d      = frame_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    start_c      = 1'b0;
    word_c       = '0;
    case (state_q)
      ST_INIT: begin
        if (tx_ready_c) begin
          if (idx_q < 4'(INIT_CMDS)) begin
            start_c = 1'b1;
            word_c  = init_word(idx_q[2:0], INTENSITY);
            idx_d   = idx_q + 4'd1;
          end else begin
            state_d = ST_SNAP;
            idx_d   = '0;
          end
        end
      end
      ST_SNAP: begin
        // Row 0 comes straight from matrix so it matches the snapshot taken this cycle.
        start_c = 1'b1;
        word_c  = row_word(matrix, 3'd0);
        frame_d = matrix;
        idx_d   = 4'd1;
        state_d = ST_ROWS;
      end
      ST_ROWS: begin
        if (tx_done_c) begin
          if (idx_q < 4'(ROWS)) begin
            start_c = 1'b1;
            word_c  = row_word(frame_q, idx_q[2:0]);
            idx_d   = idx_q + 4'd1;
          end else begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            wait_d       = '0;
            state_d      = ST_WAIT;
          end
        end
      end
      default: begin
        if (wait_q == WAIT_LAST) begin
          busy_d  = 1'b1;
          state_d = ST_SNAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      idx_q        <= '0;
      wait_q       <= '0;
      frame_q      <= '0;
      busy_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wait_q       <= wait_d;
      frame_q      <= frame_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  spi_word_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .start   (start_c),
    .word    (word_c),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .cs_n    (spi_cs_n),
    .ready_c (tx_ready_c),
    .done_c  (tx_done_c)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max7219_matrix_driver.sv
// Self-checking bench: decodes SPI words from one driver instance and frame timing from a second.
module tb_max7219_matrix_driver;

  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_a, reset_b;
  logic [255:0] mat_a, mat_b;
  logic         sclk_a, mosi_a, cs_n_a, busy_a, fd_a;
  logic         sclk_b, mosi_b, cs_n_b, busy_b, fd_b;

  max7219_matrix_driver #(.CLK_DIV(2), .REFRESH_CYCLES(20), .INTENSITY(4'd8)) dut_a (
    .clk(clk), .reset(reset_a), .matrix(mat_a), .spi_sclk(sclk_a), .spi_mosi(mosi_a),
    .spi_cs_n(cs_n_a), .busy(busy_a), .frame_done(fd_a)
  );

  max7219_matrix_driver #(.CLK_DIV(1), .REFRESH_CYCLES(20), .INTENSITY(4'd8)) dut_b (
    .clk(clk), .reset(reset_b), .matrix(mat_b), .spi_sclk(sclk_b), .spi_mosi(mosi_b),
    .spi_cs_n(cs_n_b), .busy(busy_b), .frame_done(fd_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI decoder and line-discipline monitor for dut_a
  logic        prev_sclk = 1'b0, prev_mosi = 1'b0, prev_cs = 1'b1;
  logic [63:0] sh = '0;
  int          nbits = 0, cs_len = 0, first_cs_len = 0, falls = 0, viol = 0;
  logic [63:0] words[$];

  always @(negedge clk) begin
    if (sclk_a && prev_sclk && (mosi_a !== prev_mosi)) viol++;
    if (cs_n_a && sclk_a) viol++;
    if (!cs_n_a && prev_cs) begin
      falls++;
      nbits  = 0;
      cs_len = 0;
    end
    if (!cs_n_a) cs_len++;
    if (!cs_n_a && sclk_a && !prev_sclk) begin
      sh = {sh[62:0], mosi_a};
      nbits++;
    end
    if (cs_n_a && !prev_cs) begin
      if (nbits == 64) words.push_back(sh);
      if (first_cs_len == 0) first_cs_len = cs_len;
    end
    prev_sclk = sclk_a;
    prev_mosi = mosi_a;
    prev_cs   = cs_n_a;
  end

  // frame_done / busy timing monitor for dut_b
  int   fd_cnt = 0, fd1 = 0, fd2 = 0, busy_rise = -1, fd_viol = 0;
  logic prev_fd = 1'b0, prev_busy_b = 1'b1;

  always @(negedge clk) begin
    if (fd_b && prev_fd) fd_viol++;
    if (fd_b && busy_b) fd_viol++;
    if (fd_b) begin
      if (fd_cnt == 0) fd1 = cyc;
      else if (fd_cnt == 1) fd2 = cyc;
      fd_cnt++;
    end
    if (busy_b && !prev_busy_b && fd_cnt == 1 && busy_rise < 0) busy_rise = cyc;
    prev_fd     = fd_b;
    prev_busy_b = busy_b;
  end

  typedef struct {
    string       name;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[21];

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    logic [63:0] act;
    tbl[0]  = '{"init_disptest",  {4{16'h0F00}}};
    tbl[1]  = '{"init_decode",    {4{16'h0900}}};
    tbl[2]  = '{"init_scanlimit", {4{16'h0B07}}};
    tbl[3]  = '{"init_intensity", {4{16'h0A08}}};
    tbl[4]  = '{"init_shutdown",  {4{16'h0C01}}};
    tbl[5]  = '{"f1_row0", 64'h0100_0100_0100_0101};
    tbl[6]  = '{"f1_row1", 64'h0200_0200_0200_0200};
    tbl[7]  = '{"f1_row2", 64'h0300_0300_0300_0300};
    tbl[8]  = '{"f1_row3", 64'h0400_0400_0400_0400};
    tbl[9]  = '{"f1_row4", 64'h0500_0500_0500_0500};
    tbl[10] = '{"f1_row5", 64'h0600_0600_0600_0600};
    tbl[11] = '{"f1_row6", 64'h0700_0700_0700_0700};
    tbl[12] = '{"f1_row7", 64'h0880_0800_0800_0800};
    tbl[13] = '{"f2_row0", 64'h01FF_01FF_01FF_01FF};
    tbl[14] = '{"f2_row1", 64'h02FF_02FF_02FF_02FF};
    tbl[15] = '{"f2_row2", 64'h03FF_03FF_03FF_03FF};
    tbl[16] = '{"f2_row3", 64'h04FF_04FF_04FF_04FF};
    tbl[17] = '{"f2_row4", 64'h05FF_05FF_05FF_05FF};
    tbl[18] = '{"f2_row5", 64'h06FF_06FF_06FF_06FF};
    tbl[19] = '{"f2_row6", 64'h07FF_07FF_07FF_07FF};
    tbl[20] = '{"f2_row7", 64'h08FF_08FF_08FF_08FF};

    reset_a = 1'b1;
    reset_b = 1'b1;
    mat_a   = '0;
    mat_a[0]   = 1'b1;
    mat_a[255] = 1'b1;
    mat_b   = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 64'(cs_n_a), 64'd1);
    chk("rst_sclk", 64'(sclk_a), 64'd0);
    chk("rst_mosi", 64'(mosi_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd1);
    chk("rst_frame_done", 64'(fd_a), 64'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(negedge clk);
    chk("cs_n_low_cycle1", 64'(cs_n_a), 64'd0);

    // Change the frame right after the first snapshot; frame 1 must still show the old image.
    while (falls < 6 && cyc < LIMIT) begin @(posedge clk); #1; end
    chk("snap_reached", 64'(falls >= 6), 64'd1);
    mat_a = '1;

    // Reset while bit 30 of row 3 (frame 3) is in its sclk-high phase.
    while (!(words.size() == 24 && nbits == 34) && cyc < LIMIT) begin @(negedge clk); #1; end
    chk("bit30_reached", 64'(words.size() == 24 && nbits == 34), 64'd1);
    chk("pre_rst_sclk_high", 64'(sclk_a), 64'd1);
    reset_a = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cs_n", 64'(cs_n_a), 64'd1);
    chk("midrst_sclk", 64'(sclk_a), 64'd0);
    chk("midrst_busy", 64'(busy_a), 64'd1);
    repeat (2) @(negedge clk);
    reset_a = 1'b0;

    while (words.size() < 25 && cyc < LIMIT) begin @(posedge clk); #1; end
    act = (words.size() > 24) ? words[24] : 'x;
    chk("restart_word", act, {4{16'h0F00}});
    chk("partial_discarded", 64'(words.size()), 64'd25);

    while (fd_cnt < 2 && cyc < LIMIT) begin @(posedge clk); #1; end
    chk("fd_count", 64'(fd_cnt >= 2), 64'd1);

    for (int i = 0; i < 21; i++) begin
      act = (i < words.size()) ? words[i] : 'x;
      chk(tbl[i].name, act, tbl[i].exp);
    end

    chk("first_cs_low_len", 64'(first_cs_len), 64'd258);
    chk("line_discipline", 64'(viol), 64'd0);
    chk("fd_pulse_width", 64'(fd_viol), 64'd0);
    chk("fd_spacing", 64'(fd2 - fd1), 64'd1061);
    chk("snap_after_wait", 64'(busy_rise - fd1), 64'd20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
